alsu_pipe: RTL and testbench

//  Parametrised second-generation ALSU: WIDTH-bit operands with a valid/ready input handshake and a registered

---
 rtl/alsu_pkg.sv | 22 ++
 rtl/alsu_if.sv | 33 +++
 rtl/alsu_seq_mult.sv | 65 ++++++
 rtl/alsu_pipe.sv | 148 ++++++++++++++
 tb/tb_alsu_pipe.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/alsu_pkg.sv
// Shared opcode map, FSM encoding and request error check for the ALSU.
package alsu_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_XOR  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_SHF  = 3'd4;
    localparam logic [2:0] OP_ROT  = 3'd5;
    localparam logic [2:0] OP_INV6 = 3'd6;
    localparam logic [2:0] OP_INV7 = 3'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    // Reserved opcodes are always illegal; reductions only make sense for AND/XOR.
    function automatic logic is_err(input logic [2:0] op, input logic red_a, input logic red_b);
        return (op == OP_INV6) || (op == OP_INV7) ||
               ((red_a | red_b) && (op >= OP_ADD) && (op <= OP_ROT));
    endfunction

endpackage

// File: rtl/alsu_if.sv
// Request/result bundle between operand sources, the ALSU and the LED fabric.
interface alsu_if #(
    parameter int WIDTH = 3,
    parameter int LED_W = 16
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2:0]           opcode;
    logic                 cin;
    logic                 serial_in;
    logic                 direction;
    logic                 red_op_A;
    logic                 red_op_B;
    logic                 bypass_A;
    logic                 bypass_B;
    logic [2*WIDTH-1:0]   out;
    logic                 out_valid;
    logic [LED_W-1:0]     leds;

    modport slave (
        input  in_valid, A, B, opcode, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B,
        output in_ready, out, out_valid, leds
    );

    modport master (
        output in_valid, A, B, opcode, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B,
        input  in_ready, out, out_valid, leds
    );
endinterface

// File: rtl/alsu_seq_mult.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
module alsu_seq_mult #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;

    // Load operands on start, then add one shifted partial product per busy cycle.
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_d = 1'b0;
        end
    end

    // Reset aborts any multiplication in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == CW'(1));
    assign product = acc_q;

endmodule

// File: rtl/alsu_pipe.sv
// ALSU top: request capture, decode/error, multiply FSM, result register and error blinker.
//  state   | meaning
//  ST_IDLE | accepting requests, single-cycle ops complete one cycle after accept
//  ST_MUL  | multiplier iterating, requests held off
module alsu_pipe #(
    parameter int WIDTH          = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter     FULL_ADDER     = "ON",
    parameter int LED_W          = 16,
    parameter int BLINK_DIV      = 4
) (
    input  logic   clk,
    input  logic   rst,
    alsu_if.slave  bus
);
    import alsu_pkg::*;

    localparam bit PRI_A = (INPUT_PRIORITY == "A");
    localparam bit FA_ON = (FULL_ADDER == "ON");
    localparam int OW    = 2 * WIDTH;
    localparam int BW    = $clog2(BLINK_DIV + 1);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             cin_q, cin_d, sin_q, sin_d, dir_q, dir_d;
    logic             ra_q, ra_d, rb_q, rb_d, ba_q, ba_d, bb_q, bb_d;
    logic             req_q, req_d, mul_fin_q, mul_fin_d, err_q, err_d;
    logic [0:0]       state_q, state_d;
    logic [OW-1:0]    out_q, out_d, op_res, mul_prod;
    logic             out_valid_q, out_valid_d;
    logic [LED_W-1:0] leds_q, leds_d;
    logic [BW-1:0]    blink_q, blink_d;
    logic             in_ready, accept, mul_start, mul_busy, mul_done, cap_err;
    logic [WIDTH-1:0] byp_val, red_src;
    logic             red_bit;
    logic [WIDTH:0]   sum;

    assign in_ready = (state_q == ST_IDLE) && !mul_busy;
    assign accept   = bus.in_valid && in_ready;
    assign cap_err  = is_err(op_q, ra_q, rb_q);

    alsu_seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.A),
        .b       (bus.B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Capture the request on accept; decide from live inputs whether it goes to the multiplier.
    always_comb begin
        mul_start = accept && !(bus.bypass_A || bus.bypass_B) && (bus.opcode == OP_MUL) &&
                    !is_err(bus.opcode, bus.red_op_A, bus.red_op_B);
        a_d   = accept ? bus.A         : a_q;
        b_d   = accept ? bus.B         : b_q;
        op_d  = accept ? bus.opcode    : op_q;
        cin_d = accept ? bus.cin       : cin_q;
        sin_d = accept ? bus.serial_in : sin_q;
        dir_d = accept ? bus.direction : dir_q;
        ra_d  = accept ? bus.red_op_A  : ra_q;
        rb_d  = accept ? bus.red_op_B  : rb_q;
        ba_d  = accept ? bus.bypass_A  : ba_q;
        bb_d  = accept ? bus.bypass_B  : bb_q;
        req_d     = accept && !mul_start;
        mul_fin_d = mul_done;
        state_d   = state_q;
        if (state_q == ST_IDLE && mul_start) state_d = ST_MUL;
        else if (state_q == ST_MUL && mul_done) state_d = ST_IDLE;
    end

    // Single-cycle result from the captured request: bypass, then error, then opcode.
    always_comb begin
        byp_val = (ba_q && (!bb_q || PRI_A)) ? a_q : b_q;
        red_src = (ra_q && (!rb_q || PRI_A)) ? a_q : b_q;
        red_bit = (op_q == OP_AND) ? &red_src : ^red_src;
        sum     = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q & FA_ON};
        op_res  = '0;
        if (ba_q || bb_q) begin
            op_res = {{WIDTH{1'b0}}, byp_val};
        end else if (!cap_err) begin
            case (op_q)
                OP_AND:  op_res = (ra_q || rb_q) ? {{(OW-1){1'b0}}, red_bit} : {{WIDTH{1'b0}}, a_q & b_q};
                OP_XOR:  op_res = (ra_q || rb_q) ? {{(OW-1){1'b0}}, red_bit} : {{WIDTH{1'b0}}, a_q ^ b_q};
                OP_ADD:  op_res = {{(WIDTH-1){1'b0}}, sum};
                OP_SHF:  op_res = dir_q ? {out_q[OW-2:0], sin_q} : {sin_q, out_q[OW-1:1]};
                OP_ROT:  op_res = dir_q ? {out_q[OW-2:0], out_q[OW-1]} : {out_q[0], out_q[OW-1:1]};
                default: op_res = '0;
            endcase
        end
    end

    // Result register, error latch and LED blink down-counter.
    always_comb begin
        out_d       = out_q;
        out_valid_d = req_q || mul_fin_q;
        err_d       = err_q;
        leds_d      = leds_q;
        blink_d     = blink_q;
        if (req_q) out_d = op_res;
        else if (mul_fin_q) out_d = mul_prod;
        if (req_q && !(ba_q || bb_q) && cap_err) begin
            err_d   = 1'b1;
            leds_d  = '1;
            blink_d = BW'(BLINK_DIV - 1);
        end else if (req_q || mul_fin_q) begin
            err_d   = 1'b0;
            leds_d  = '0;
            blink_d = '0;
        end else if (err_q) begin
            if (blink_q == '0) begin
                leds_d  = ~leds_q;
                blink_d = BW'(BLINK_DIV - 1);
            end else begin
                blink_d = blink_q - BW'(1);
            end
        end
    end

    // All state flops share the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0; b_q <= '0; op_q <= '0;
            cin_q <= 1'b0; sin_q <= 1'b0; dir_q <= 1'b0;
            ra_q <= 1'b0; rb_q <= 1'b0; ba_q <= 1'b0; bb_q <= 1'b0;
            req_q <= 1'b0; mul_fin_q <= 1'b0; err_q <= 1'b0;
            state_q <= ST_IDLE;
            out_q <= '0; out_valid_q <= 1'b0;
            leds_q <= '0; blink_q <= '0;
        end else begin
            a_q <= a_d; b_q <= b_d; op_q <= op_d;
            cin_q <= cin_d; sin_q <= sin_d; dir_q <= dir_d;
            ra_q <= ra_d; rb_q <= rb_d; ba_q <= ba_d; bb_q <= bb_d;
            req_q <= req_d; mul_fin_q <= mul_fin_d; err_q <= err_d;
            state_q <= state_d;
            out_q <= out_d; out_valid_q <= out_valid_d;
            leds_q <= leds_d; blink_q <= blink_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.leds      = leds_q;

endmodule

// File: tb/tb_alsu_pipe.sv
// Directed bench for alsu_pipe at WIDTH=4, LED_W=16, BLINK_DIV=4.
module tb_alsu_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alsu_if #(.WIDTH(4), .LED_W(16)) bus ();

    alsu_pipe #(
        .WIDTH(4), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(16), .BLINK_DIV(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic si, input logic dir,
                         input logic ra, input logic rb, input logic ba, input logic bb);
        bus.in_valid  = 1'b1;
        bus.opcode    = op;
        bus.A         = a;
        bus.B         = b;
        bus.cin       = c;
        bus.serial_in = si;
        bus.direction = dir;
        bus.red_op_A  = ra;
        bus.red_op_B  = rb;
        bus.bypass_A  = ba;
        bus.bypass_B  = bb;
    endtask

    task automatic idle();
        drive(3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int strobes;
        int lat;
        logic [7:0] out_at;

        // 1: reset with random inputs
        drive(3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        bus.in_valid = 1'($urandom);
        repeat (3) tick();
        chk("rst_out", 32'(bus.out), 32'h0);
        chk("rst_ov", 32'(bus.out_valid), 32'h0);
        chk("rst_leds", 32'(bus.leds), 32'h0);
        chk("rst_rdy", 32'(bus.in_ready), 32'h1);
        rst = 1'b0;
        idle();
        strobes = 0;
        repeat (3) begin
            tick();
            if (bus.out_valid) strobes++;
        end
        chk("post_rst_strobes", 32'(strobes), 32'h0);

        // 2: ADD then back-to-back XOR
        drive(3'd2, 4'd15, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("add_ov_early", 32'(bus.out_valid), 32'h0);
        drive(3'd1, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("add_out", 32'(bus.out), 32'h11);
        chk("add_ov", 32'(bus.out_valid), 32'h1);
        idle();
        tick();
        chk("xor_out", 32'(bus.out), 32'h06);
        chk("xor_ov", 32'(bus.out_valid), 32'h1);
        tick();
        chk("hold_ov", 32'(bus.out_valid), 32'h0);
        chk("hold_out", 32'(bus.out), 32'h06);

        // 3: MULT 13*11, a stalled XOR request is ignored, bypass_A+MULT accepted as mult completes
        drive(3'd3, 4'd13, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(3'd1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("mul_rdy_low", 32'(bus.in_ready), 32'h0);
            chk("mul_ov_low", 32'(bus.out_valid), 32'h0);
            tick();
        end
        chk("mul_rdy_back", 32'(bus.in_ready), 32'h1);
        chk("mul_ov_pre", 32'(bus.out_valid), 32'h0);
        drive(3'd3, 4'd13, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("mul_out", 32'(bus.out), 32'h8F);
        chk("mul_ov", 32'(bus.out_valid), 32'h1);
        idle();
        tick();
        chk("bypA_out", 32'(bus.out), 32'h0D);
        chk("bypA_ov", 32'(bus.out_valid), 32'h1);
        chk("bypA_rdy", 32'(bus.in_ready), 32'h1);

        // 4: invalid opcode, LED blink, recovery, reduction error, bypass with opcode 7
        drive(3'd6, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        chk("err6_out", 32'(bus.out), 32'h0);
        chk("err6_ov", 32'(bus.out_valid), 32'h1);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("blink_%0d", k), 32'(bus.leds), ((k / 4) % 2 == 0) ? 32'hFFFF : 32'h0);
            tick();
        end
        drive(3'd2, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        chk("clr_out", 32'(bus.out), 32'h2);
        chk("clr_leds", 32'(bus.leds), 32'h0);
        drive(3'd2, 4'd7, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        chk("redadd_out", 32'(bus.out), 32'h0);
        chk("redadd_leds", 32'(bus.leds), 32'hFFFF);
        drive(3'd7, 4'd3, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        chk("bypB7_out", 32'(bus.out), 32'h09);
        chk("bypB7_leds", 32'(bus.leds), 32'h0);
        drive(3'd2, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        chk("add2_out", 32'(bus.out), 32'h2);
        chk("add2_leds", 32'(bus.leds), 32'h0);

        // 5: SHIFT / ROTATE on the result register, reductions
        drive(3'd2, 4'd15, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(3'd4, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("pre_shift", 32'(bus.out), 32'h11);
        drive(3'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("shift_out", 32'(bus.out), 32'h23);
        drive(3'd0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rot_out", 32'(bus.out), 32'h91);
        drive(3'd1, 4'h1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("redand_out", 32'(bus.out), 32'h1);
        idle();
        tick();
        chk("redxorB_out", 32'(bus.out), 32'h0);
        drive(3'd0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        chk("redand2_out", 32'(bus.out), 32'h1);

        // 6: reset two cycles into MULT, then a clean MULT
        drive(3'd3, 4'd13, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_ov", 32'(bus.out_valid), 32'h0);
        chk("abort_out", 32'(bus.out), 32'h0);
        chk("abort_rdy", 32'(bus.in_ready), 32'h1);
        tick();
        tick();
        rst = 1'b0;
        strobes = 0;
        repeat (6) begin
            tick();
            if (bus.out_valid) strobes++;
        end
        chk("abort_strobes", 32'(strobes), 32'h0);
        drive(3'd3, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        lat = 99;
        out_at = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.out_valid && lat == 99) begin
                lat = k;
                out_at = bus.out;
            end
        end
        chk("mul2_lat", 32'(lat), 32'd5);
        chk("mul2_out", 32'(out_at), 32'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
